mem_port_arbiter: RTL and testbench

Parametrised memory-port controller sharing one processor-style memory bus (24-bit address, 32-bit data, MemLength/MemRd/MemWr/MemEnable with MemRdy completion) among NUM_CH requesters, e.g. instruction fetch, data memop and a DMA engine. It arbitrates round-robin, runs one access at a time, and returns data and a done pulse to the winner. It adds what the single-master processor bus lacks: multiple masters, fairness, and a MemRdy timeout that reports an error instead of hanging.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_arbiter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: controller states and MemLength encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    localparam logic MEMLEN_BYTE = 1'b0;
    localparam logic MEMLEN_WORD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last granted channel
// and returns the first requester found.
module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    lastGrant,
    output logic              anyReq,
    output logic [IDW-1:0]    grant
);

    always_comb begin
        anyReq = 1'b0;
        grant  = '0;
        // Scan farthest-to-nearest so the nearest requester after lastGrant is written last.
        for (int unsigned d = NUM_CH; d >= 1; d--) begin
            int unsigned idx;
            idx = (32'(lastGrant) + d) % NUM_CH;
            if (req[idx]) begin
                anyReq = 1'b1;
                grant  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one processor-style memory bus among NUM_CH requesters, using round-robin arbitration.
// One access runs at a time, and a missing MemRdy aborts the access with ChErr after TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_CH-1:0]        ChReq,
    input  logic [NUM_CH-1:0]        ChWr,
    input  logic [NUM_CH-1:0]        ChLen,
    input  logic [NUM_CH*ADDR_W-1:0] ChAddr,
    input  logic [NUM_CH*DATA_W-1:0] ChWData,
    output logic [NUM_CH-1:0]        ChDone,
    output logic [NUM_CH-1:0]        ChErr,
    output logic [DATA_W-1:0]        ChRData,
    output logic [ADDR_W-1:0]        MemAddr,
    output logic [DATA_W-1:0]        toMemData,
    input  logic [DATA_W-1:0]        fromMemData,
    output logic                     MemLength,
    output logic                     MemRd,
    output logic                     MemWr,
    output logic                     MemEnable,
    input  logic                     MemRdy,
    output logic                     Busy,
    output logic [$clog2(NUM_CH)-1:0] GrantId
);

    localparam int IDW   = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arbState_t         state;
    logic [IDW-1:0]    lastGrant;
    logic [IDW-1:0]    grantId;
    logic [IDW-1:0]    pick;
    logic              anyReq;
    logic              wrReg;
    logic              lenReg;
    logic              errReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdReg;
    logic [DATA_W-1:0] rdReg;
    logic [CNT_W-1:0]  toCnt;
    logic              timedOut;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDW(IDW)) uArb (
        .req      (ChReq),
        .lastGrant(lastGrant),
        .anyReq   (anyReq),
        .grant    (pick)
    );

    // toCnt counts completed ACCESS cycles, so CNT_LAST is reached in the TIMEOUT-th one.
    assign timedOut = (TIMEOUT != 0) && (toCnt == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            lastGrant <= IDW'(NUM_CH - 1);
            grantId   <= '0;
            wrReg     <= 1'b0;
            lenReg    <= MEMLEN_BYTE;
            errReg    <= 1'b0;
            addrReg   <= '0;
            wdReg     <= '0;
            rdReg     <= '0;
            toCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantId   <= pick;
                        lastGrant <= pick;
                        wrReg     <= ChWr[pick];
                        lenReg    <= ChLen[pick];
                        addrReg   <= ChAddr[pick*ADDR_W +: ADDR_W];
                        wdReg     <= ChWData[pick*DATA_W +: DATA_W];
                        errReg    <= 1'b0;
                        toCnt     <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (MemRdy) begin
                        rdReg <= (lenReg == MEMLEN_WORD) ? fromMemData
                                                         : DATA_W'(fromMemData[7:0]);
                        state <= RESP;
                    end else if (timedOut) begin
                        rdReg  <= '0;
                        errReg <= 1'b1;
                        state  <= RESP;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MemEnable = (state == ACCESS);
    assign MemRd     = MemEnable && !wrReg;
    assign MemWr     = MemEnable && wrReg;
    assign MemAddr   = addrReg;
    assign toMemData = wdReg;
    assign MemLength = lenReg;
    assign Busy      = (state != IDLE);
    assign GrantId   = grantId;
    assign ChRData   = rdReg;
    assign ChDone    = (state == RESP) ? (NUM_CH'(1) << grantId) : '0;
    assign ChErr     = (state == RESP && errReg) ? (NUM_CH'(1) << grantId) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; expectations come from a transaction-level
// round-robin and memory-latency model.
module tb_mem_port_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int TO  = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NCH-1:0]    ChReq, ChWr, ChLen;
    logic [NCH*AW-1:0] ChAddr;
    logic [NCH*DW-1:0] ChWData;
    logic [NCH-1:0]    ChDone, ChErr;
    logic [DW-1:0]     ChRData, toMemData, fromMemData;
    logic [AW-1:0]     MemAddr;
    logic              MemLength, MemRd, MemWr, MemEnable, MemRdy, Busy;
    logic [1:0]        GrantId;

    mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .ChReq(ChReq), .ChWr(ChWr), .ChLen(ChLen),
        .ChAddr(ChAddr), .ChWData(ChWData), .ChDone(ChDone), .ChErr(ChErr),
        .ChRData(ChRData), .MemAddr(MemAddr), .toMemData(toMemData),
        .fromMemData(fromMemData), .MemLength(MemLength), .MemRd(MemRd),
        .MemWr(MemWr), .MemEnable(MemEnable), .MemRdy(MemRdy), .Busy(Busy),
        .GrantId(GrantId)
    );

    always #5 Clk = ~Clk;

    int passCnt  = 0;
    int failCnt  = 0;
    int totalCnt = 0;
    int modelLast;
    logic          wrS  [NCH];
    logic          lenS [NCH];
    logic [AW-1:0] addrS[NCH];
    logic [DW-1:0] wdS  [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setCh(input int ch, input logic wr, input logic len,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrS[ch] = wr; lenS[ch] = len; addrS[ch] = a; wdS[ch] = d;
        ChWr[ch] = wr; ChLen[ch] = len;
        ChAddr[ch*AW +: AW]  = a;
        ChWData[ch*DW +: DW] = d;
        ChReq[ch] = 1'b1;
    endtask

    // The winner is the first requester found after the last winner, in modular channel order.
    function automatic int rrPick(input logic [NCH-1:0] req, input int last);
        for (int d = 1; d <= NCH; d++)
            if (req[(last + d) % NCH]) return (last + d) % NCH;
        return -1;
    endfunction

    task automatic checkAllZero(input string tag);
        chk({tag, ".done"}, ChDone, 0);     chk({tag, ".err"}, ChErr, 0);
        chk({tag, ".rdata"}, ChRData, 0);   chk({tag, ".addr"}, MemAddr, 0);
        chk({tag, ".wdata"}, toMemData, 0); chk({tag, ".len"}, MemLength, 0);
        chk({tag, ".rd"}, MemRd, 0);        chk({tag, ".wr"}, MemWr, 0);
        chk({tag, ".en"}, MemEnable, 0);    chk({tag, ".busy"}, Busy, 0);
        chk({tag, ".gid"}, GrantId, 0);
    endtask

    // Entered #1 after an edge with the DUT in IDLE; returns #1 after the edge back into IDLE.
    // lat = ACCESS cycle in which MemRdy rises; lat > TO models a memory that never answers.
    task automatic runTxn(input int lat, input logic [DW-1:0] memData, input bit drop, input bit noise);
        int ch, nAcc;
        bit expErr;
        logic [DW-1:0] expData;
        ch = rrPick(ChReq, modelLast);
        if (ch < 0) return;
        modelLast = ch;
        expErr  = (lat > TO);
        nAcc    = expErr ? TO : lat;
        expData = expErr ? '0 : (lenS[ch] ? memData : {24'h0, memData[7:0]});
        MemRdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        fromMemData = $urandom();
        @(negedge Clk);
        chk("idleBusy", Busy, 0);
        chk("idleDone", ChDone, 0);
        @(posedge Clk); #1;
        for (int c = 1; c <= nAcc; c++) begin
            MemRdy = (c == lat);
            fromMemData = (c == lat) ? memData : $urandom();
            @(negedge Clk);
            chk("memEnable", MemEnable, 1);
            chk("memRd", MemRd, !wrS[ch]);
            chk("memWr", MemWr, wrS[ch]);
            chk("memAddr", MemAddr, addrS[ch]);
            chk("memLength", MemLength, lenS[ch]);
            chk("toMemData", toMemData, wdS[ch]);
            chk("grantId", GrantId, ch);
            chk("accDone", ChDone, 0);
            @(posedge Clk); #1;
        end
        MemRdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        fromMemData = $urandom();
        @(negedge Clk);
        chk("chDone", ChDone, 64'(1) << ch);
        chk("chErr", ChErr, expErr ? (64'(1) << ch) : 0);
        chk("chRData", ChRData, expData);
        chk("respEnable", MemEnable, 0);
        if (drop) ChReq[ch] = 1'b0;
        @(posedge Clk); #1;
        MemRdy = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; ChReq = '0; ChWr = '0; ChLen = '0; ChAddr = '0; ChWData = '0;
        fromMemData = '0; MemRdy = 1'b0; modelLast = NCH - 1;
        for (int i = 0; i < NCH; i++) begin
            wrS[i] = 1'b0; lenS[i] = 1'b0; addrS[i] = '0; wdS[i] = '0;
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkAllZero("reset");
        @(posedge Clk); #1;
        Reset = 1'b1;

        // single word read, three-cycle memory
        setCh(1, 1'b0, 1'b1, 24'h000100, 32'h0);
        runTxn(3, 32'hDEADBEEF, 1, 0);
        // byte read zero-extends, byte write
        setCh(0, 1'b0, 1'b0, 24'h000200, 32'h0);
        runTxn(1, 32'h12345678, 1, 0);
        setCh(2, 1'b1, 1'b0, 24'h000300, 32'h000000AB);
        runTxn(2, 32'h0, 1, 0);

        // fairness with all requests held
        setCh(0, 1'b0, 1'b1, 24'h001000, 32'h0);
        setCh(1, 1'b1, 1'b1, 24'h002000, 32'h11112222);
        setCh(2, 1'b0, 1'b1, 24'h003000, 32'h0);
        for (int i = 0; i < 6; i++) runTxn(1, 32'hA5A50000 + 32'(i), 0, 0);
        ChReq = '0;

        // timeout abort, then MemRdy in the last allowed cycle
        setCh(1, 1'b0, 1'b1, 24'h00ABCD, 32'h0);
        runTxn(99, 32'hFFFFFFFF, 1, 0);
        setCh(0, 1'b0, 1'b1, 24'h00BCDE, 32'h0);
        runTxn(TO, 32'hCAFEF00D, 1, 0);

        // reset during ACCESS
        setCh(1, 1'b1, 1'b1, 24'h00CDEF, 32'h55667788);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("preResetEnable", MemEnable, 1);
        Reset = 1'b0;
        @(negedge Clk);
        checkAllZero("midReset");
        @(posedge Clk); #1;
        Reset = 1'b1;
        modelLast = NCH - 1;
        setCh(0, 1'b0, 1'b1, 24'h00DEF0, 32'h0);
        runTxn(2, 32'h0BADF00D, 1, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++)
                if (!ChReq[c] && $urandom_range(0, 2) == 0)
                    setCh(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          24'($urandom()), $urandom());
            if (ChReq == '0)
                setCh(int'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 24'($urandom()), $urandom());
            runTxn(int'($urandom_range(1, TO + 2)), $urandom(), 1, 1);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
